// File: rtl/lpc_host_pkg.sv
// lpc_host_pkg: shared types and constants for the LPC host I/O cycle generator.
//   lpc_state_e  - host cycle state (one value per LPC cycle phase)
//   CT_*         - CYCTYPE/DIR nibbles for ISA I/O read and write
//   SYNC_*       - SYNC codes returned by the peripheral
//   LAD_IDLE     - idle / turnaround value on LAD
//   lad_nibble   - selects a nibble of the address, most significant first
package lpc_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    CTDIR,
    ADDR,
    WDATA,
    TAR_H,
    TAR_F,
    SYNC,
    RDATA,
    TAR_P1,
    TAR_P2,
    ABORT,
    DONE
  } lpc_state_e;

  localparam logic [3:0] CT_IORD    = 4'b0000;
  localparam logic [3:0] CT_IOWR    = 4'b0010;
  localparam logic [3:0] START_ISA  = 4'b0000;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;
  localparam logic [3:0] LAD_IDLE   = 4'b1111;

  // Address goes out most significant nibble first: idx 0 -> [15:12].
  function automatic logic [3:0] lad_nibble(input logic [15:0] addr, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      default: nib = addr[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lpc_host_if.sv
// lpc_host_if: request/response handshake plus the LPC pin-side signals of
// the host.
//   master modport - the lpc_host itself (accepts requests, drives LFRAME#/LAD)
//   slave  modport - the request source and bus/peripheral side around it
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata - request channel
//   rsp_valid/rsp_rdata/rsp_err                      - one-cycle response
//   lpc_frame, lpc_ad_out, lpc_ad_oe                 - LFRAME# and LAD drive
//   lpc_ad_in                                        - sampled LAD
interface lpc_host_if;
  import lpc_host_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output lpc_frame, lpc_ad_out, lpc_ad_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  lpc_frame, lpc_ad_out, lpc_ad_oe
  );

endinterface

// File: rtl/lpc_host.sv
// lpc_host: LPC host-side ISA I/O cycle generator.
// Accepts single-byte I/O read/write requests and runs START, CYCTYPE/DIR,
// ADDR, (WDATA), TAR, SYNC, (RDATA), TAR on LAD[3:0]/LFRAME#, then reports
// the result on a one-cycle response strobe. The LAD tristate lives above
// this module; lpc_ad_oe says when the host owns the bus.
// Ports:
//   lpc_clk  - clock, all logic on the rising edge
//   lpc_rst  - asynchronous active-high reset
//   bus      - lpc_host_if.master (request, response and LPC pin signals)
// Parameters:
//   NO_DEV_CYCLES - consecutive SYNC=1111 cycles before aborting
//   WAIT_LIMIT    - SYNC short/long wait cycles before aborting
module lpc_host
  import lpc_host_pkg::*;
#(
  parameter int NO_DEV_CYCLES = 3,
  parameter int WAIT_LIMIT    = 1024
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  lpc_host_if.master bus
);

  localparam int ND_W = $clog2(NO_DEV_CYCLES + 1);
  localparam int WT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [ND_W-1:0] ND_MAX  = ND_W'(NO_DEV_CYCLES);
  localparam logic [ND_W-1:0] ND_LAST = ND_W'(NO_DEV_CYCLES - 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(WAIT_LIMIT);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(WAIT_LIMIT - 1);

  lpc_state_e      state_q, state_d;
  logic            ready_q;
  logic            write_q;
  logic [15:0]     addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      rdata_q;
  logic            err_q;
  logic [1:0]      nib_cnt_q;
  logic [2:0]      abt_cnt_q;
  logic [WT_W-1:0] wait_cnt_q;
  logic [ND_W-1:0] nodev_cnt_q;

  logic            accept;
  logic [3:0]      sync_code;
  logic            sync_adv;
  logic            sync_wait;
  logic            sync_none;

  assign accept    = bus.req_valid && ready_q;
  assign sync_code = bus.lpc_ad_in;
  assign sync_adv  = (sync_code == SYNC_READY) || (sync_code == SYNC_ERR);
  assign sync_wait = (sync_code == SYNC_SHORT) || (sync_code == SYNC_LONG);
  assign sync_none = (sync_code == LAD_IDLE);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  state_d = CTDIR;
      CTDIR:  state_d = ADDR;
      ADDR:   if (nib_cnt_q == 2'd3) state_d = write_q ? WDATA : TAR_H;
      WDATA:  if (nib_cnt_q == 2'd1) state_d = TAR_H;
      TAR_H:  state_d = TAR_F;
      TAR_F:  state_d = SYNC;
      SYNC: begin
        if (sync_adv) begin
          state_d = write_q ? TAR_P1 : RDATA;
        end else if (sync_wait) begin
          if (wait_cnt_q == WT_LAST) state_d = ABORT;
        end else if (sync_none) begin
          if (nodev_cnt_q == ND_LAST) state_d = ABORT;
        end else begin
          // Undefined SYNC code: the peripheral is confused, end the cycle.
          state_d = ABORT;
        end
      end
      RDATA:  if (nib_cnt_q == 2'd1) state_d = TAR_P1;
      TAR_P1: state_d = TAR_P2;
      TAR_P2: state_d = DONE;
      // Four cycles of LFRAME# low, then one cycle high with LAD still driven.
      ABORT:  if (abt_cnt_q == 3'd4) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin and response outputs, decoded from the current state
  always_comb begin
    bus.lpc_frame  = 1'b1;
    bus.lpc_ad_out = LAD_IDLE;
    bus.lpc_ad_oe  = 1'b0;
    case (state_q)
      START: begin
        bus.lpc_frame  = 1'b0;
        bus.lpc_ad_out = START_ISA;
        bus.lpc_ad_oe  = 1'b1;
      end
      CTDIR: begin
        bus.lpc_ad_out = write_q ? CT_IOWR : CT_IORD;
        bus.lpc_ad_oe  = 1'b1;
      end
      ADDR: begin
        bus.lpc_ad_out = lad_nibble(addr_q, nib_cnt_q);
        bus.lpc_ad_oe  = 1'b1;
      end
      WDATA: begin
        // Data goes out low nibble first.
        bus.lpc_ad_out = nib_cnt_q[0] ? wdata_q[7:4] : wdata_q[3:0];
        bus.lpc_ad_oe  = 1'b1;
      end
      TAR_H: begin
        bus.lpc_ad_oe  = 1'b1;
      end
      ABORT: begin
        bus.lpc_frame  = (abt_cnt_q == 3'd4);
        bus.lpc_ad_oe  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // State, request latch, counters and response registers
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= 8'hFF;
      err_q       <= 1'b0;
      nib_cnt_q   <= '0;
      abt_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      nodev_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Ready is registered, so it follows the state one edge later.
      ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q     <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            rdata_q     <= 8'hFF;
            err_q       <= 1'b0;
            nib_cnt_q   <= '0;
            abt_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            nodev_cnt_q <= '0;
          end
        end
        ADDR, WDATA, RDATA: begin
          if (state_q == RDATA) begin
            if (nib_cnt_q[0]) rdata_q[7:4] <= bus.lpc_ad_in;
            else              rdata_q[3:0] <= bus.lpc_ad_in;
          end
          if (state_d != state_q)        nib_cnt_q <= '0;
          else if (nib_cnt_q != 2'd3)    nib_cnt_q <= nib_cnt_q + 2'd1;
        end
        SYNC: begin
          if (sync_code == SYNC_ERR) err_q <= 1'b1;
          if (sync_wait) begin
            if (wait_cnt_q != WT_MAX) wait_cnt_q <= wait_cnt_q + WT_W'(1);
            // No-device detection wants consecutive 1111 cycles.
            nodev_cnt_q <= '0;
          end else if (sync_none) begin
            if (nodev_cnt_q != ND_MAX) nodev_cnt_q <= nodev_cnt_q + ND_W'(1);
          end
          if (state_d == ABORT) begin
            err_q   <= 1'b1;
            rdata_q <= 8'hFF;
          end
        end
        ABORT: begin
          if (abt_cnt_q != 3'd7) abt_cnt_q <= abt_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: self-checking bench for lpc_host. A peripheral model answers
// each host cycle from a per-transaction script (SYNC codes then read data);
// the expected pin trace, read data, error flag and latency come from a
// protocol-level model of the LPC I/O cycle.
module tb_lpc_host;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;

  lpc_host_if bus ();

  lpc_host #(.NO_DEV_CYCLES(3), .WAIT_LIMIT(1024)) dut (
    .lpc_clk (clk),
    .lpc_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       frame;
    logic       oe;
    logic [3:0] ad;
  } cyc_t;

  cyc_t       tr[$];   // expected pin state per cycle after accept
  logic [3:0] drv[$];  // value the peripheral puts on LAD per cycle

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          npre;
    logic [3:0]  pre;
    logic [3:0]  fin;
    logic [7:0]  x_rdata;
    bit          x_err;
    int          x_lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic f, input logic oe, input logic [3:0] ad, input logic [3:0] din);
    cyc_t c;
    c.frame = f;
    c.oe    = oe;
    c.ad    = ad;
    tr.push_back(c);
    drv.push_back(din);
  endtask

  // Protocol model: lays out the LPC I/O cycle phase by phase and applies
  // the SYNC rules to the peripheral's scripted answers.
  task automatic build_model(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                             input logic [7:0] rd, input int npre, input logic [3:0] pre,
                             input logic [3:0] fin, output logic [7:0] m_rdata,
                             output bit m_err, output int m_lat);
    int nd = 0;
    int wc = 0;
    int i = 0;
    bit done_s = 0;
    bit ab = 0;
    logic [3:0] code;
    tr.delete();
    drv.delete();
    m_err = 0;
    put(1'b0, 1'b1, 4'h0, 4'hF);
    put(1'b1, 1'b1, wr ? 4'h2 : 4'h0, 4'hF);
    for (int n = 3; n >= 0; n--) put(1'b1, 1'b1, addr[n*4 +: 4], 4'hF);
    if (wr) begin
      put(1'b1, 1'b1, wd[3:0], 4'hF);
      put(1'b1, 1'b1, wd[7:4], 4'hF);
    end
    put(1'b1, 1'b1, 4'hF, 4'hF);
    put(1'b1, 1'b0, 4'hF, 4'hF);
    while (!done_s && i < 4096) begin
      code = (i < npre) ? pre : fin;
      put(1'b1, 1'b0, 4'hF, code);
      i++;
      if (code == 4'h0) begin
        done_s = 1;
      end else if (code == 4'hA) begin
        m_err = 1;
        done_s = 1;
      end else if (code == 4'h5 || code == 4'h6) begin
        wc++;
        nd = 0;
        if (wc >= 1024) begin ab = 1; done_s = 1; end
      end else if (code == 4'hF) begin
        nd++;
        if (nd >= 3) begin ab = 1; done_s = 1; end
      end else begin
        ab = 1;
        done_s = 1;
      end
    end
    if (ab) begin
      for (int n = 0; n < 4; n++) put(1'b0, 1'b1, 4'hF, 4'hF);
      put(1'b1, 1'b1, 4'hF, 4'hF);
      m_err   = 1;
      m_rdata = 8'hFF;
    end else begin
      if (!wr) begin
        put(1'b1, 1'b0, 4'hF, rd[3:0]);
        put(1'b1, 1'b0, 4'hF, rd[7:4]);
        m_rdata = rd;
      end else begin
        m_rdata = 8'hFF;
      end
      put(1'b1, 1'b0, 4'hF, 4'hF);
      put(1'b1, 1'b0, 4'hF, 4'hF);
    end
    // Response cycle index is tr.size(); count edges from accept through
    // the edge that samples rsp_valid.
    m_lat = tr.size() + 2;
  endtask

  // Called at a negedge. Presents the request, waits for accept, then walks
  // the cycle comparing pins with the model trace and driving LAD.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                         input string tag, output logic [7:0] o_rdata, output bit o_err,
                         output int o_lat, output int t_start, output int t_rsp);
    int  n = 0;
    bit  got = 0;
    o_rdata = 8'h00;
    o_err   = 0;
    o_lat   = -1;
    t_start = -1;
    t_rsp   = -1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL %s accept: req_ready never rose", tag);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k < 4200 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.req_valid = 1'b0;
        t_start = cyc;
      end
      if (bus.rsp_valid === 1'b1) begin
        got     = 1;
        o_lat   = k + 2;
        o_rdata = bus.rsp_rdata;
        o_err   = bus.rsp_err;
        t_rsp   = cyc;
        chk({tag, " done pins"}, {bus.lpc_frame, bus.lpc_ad_oe}, 2'b10);
      end else if (k < tr.size()) begin
        chk($sformatf("%s c%0d frame", tag, k), bus.lpc_frame, tr[k].frame);
        chk($sformatf("%s c%0d oe", tag, k), bus.lpc_ad_oe, tr[k].oe);
        if (tr[k].oe) chk($sformatf("%s c%0d ad", tag, k), bus.lpc_ad_out, tr[k].ad);
      end
      bus.lpc_ad_in = (k < drv.size()) ? drv[k] : 4'hF;
    end
    bus.lpc_ad_in = 4'hF;
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL %s rsp_valid: never seen", tag);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] m_rd, o_rd;
    bit         m_e, o_e;
    int         m_l, o_l, ts, trsp, ts2, trsp2;
    int         seen_rsp, seen_frame;
    logic [3:0] pick;

    n_checks = 0;
    n_err    = 0;

    //            wr    addr      wd     rd     npre pre    fin    rdata  err lat
    vt[0] = '{1'b1, 16'h03F8, 8'h5A, 8'h00, 0, 4'h0, 4'h0, 8'hFF, 1'b0, 15};
    vt[1] = '{1'b0, 16'h03FD, 8'h00, 8'h60, 0, 4'h0, 4'h0, 8'h60, 1'b0, 15};
    vt[2] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 5, 4'h6, 4'h0, 8'hA5, 1'b0, 20};
    vt[3] = '{1'b0, 16'h0080, 8'h00, 8'h77, 3, 4'hF, 4'h0, 8'hFF, 1'b1, 18};
    vt[4] = '{1'b0, 16'h0061, 8'h00, 8'h33, 0, 4'h0, 4'hA, 8'h33, 1'b1, 15};
    vt[5] = '{1'b1, 16'h02E8, 8'hC3, 8'h00, 0, 4'h0, 4'h3, 8'hFF, 1'b1, 18};
    vt[6] = '{1'b1, 16'h0378, 8'h01, 8'h00, 2, 4'h5, 4'hA, 8'hFF, 1'b1, 17};
    vt[7] = '{1'b0, 16'h03F8, 8'h00, 8'h7E, 2, 4'hF, 4'h0, 8'h7E, 1'b0, 17};
    vt[8] = '{1'b1, 16'hFFFF, 8'hFF, 8'h00, 1, 4'h6, 4'h0, 8'hFF, 1'b0, 16};
    vt[9] = '{1'b1, 16'h0000, 8'h00, 8'h00, 3, 4'hF, 4'h0, 8'hFF, 1'b1, 20};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.lpc_ad_in = 4'hF;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst frame", bus.lpc_frame, 1'b1);
    chk("rst oe", bus.lpc_ad_oe, 1'b0);
    chk("rst ad", bus.lpc_ad_out, 4'hF);
    chk("rst ready", bus.req_ready, 1'b0);
    chk("rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst rdata", bus.rsp_rdata, 8'hFF);
    chk("rst err", bus.rsp_err, 1'b0);
    rst = 1'b0;
    chk("rel ready", bus.req_ready, 1'b0);
    @(negedge clk);
    chk("ready 1st edge", bus.req_ready, 1'b1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      build_model(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].npre, vt[i].pre,
                  vt[i].fin, m_rd, m_e, m_l);
      run_txn(vt[i].wr, vt[i].addr, vt[i].wd, $sformatf("v%0d", i), o_rd, o_e, o_l, ts, trsp);
      chk($sformatf("v%0d rdata", i), o_rd, vt[i].x_rdata);
      chk($sformatf("v%0d err", i), o_e, vt[i].x_err);
      chk($sformatf("v%0d latency", i), o_l, vt[i].x_lat);
      @(negedge clk);
      chk($sformatf("v%0d ready after rsp", i), bus.req_ready, 1'b1);
    end

    // Back-to-back writes: second START two cycles after first rsp_valid
    build_model(1'b1, 16'h03F9, 8'h11, 8'h00, 0, 4'h0, 4'h0, m_rd, m_e, m_l);
    run_txn(1'b1, 16'h03F9, 8'h11, "b2b1", o_rd, o_e, o_l, ts, trsp);
    chk("b2b1 latency", o_l, 15);
    build_model(1'b1, 16'h03FA, 8'h22, 8'h00, 0, 4'h0, 4'h0, m_rd, m_e, m_l);
    run_txn(1'b1, 16'h03FA, 8'h22, "b2b2", o_rd, o_e, o_l, ts2, trsp2);
    chk("b2b start gap", ts2 - trsp, 2);
    chk("b2b2 err", o_e, 1'b0);
    @(negedge clk);

    // Reset pulse during ADDR
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h03FD;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstmid start frame", bus.lpc_frame, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid addr oe", bus.lpc_ad_oe, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid frame", bus.lpc_frame, 1'b1);
    chk("rstmid oe", bus.lpc_ad_oe, 1'b0);
    chk("rstmid rsp_valid", bus.rsp_valid, 1'b0);
    chk("rstmid ready", bus.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid rel ready", bus.req_ready, 1'b0);
    @(negedge clk);
    chk("rstmid ready edge", bus.req_ready, 1'b1);
    seen_rsp   = 0;
    seen_frame = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.rsp_valid === 1'b1) seen_rsp++;
      if (bus.lpc_frame !== 1'b1 || bus.lpc_ad_oe !== 1'b0) seen_frame++;
      @(negedge clk);
    end
    chk("rstmid no rsp", seen_rsp, 0);
    chk("rstmid bus idle", seen_frame, 0);

    // Randomized transactions against the protocol model
    for (int i = 0; i < 40; i++) begin
      bit          r_wr;
      logic [15:0] r_addr;
      logic [7:0]  r_wd, r_rd;
      int          r_npre;
      logic [3:0]  r_pre, r_fin;
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 16'($urandom);
      r_wd   = 8'($urandom);
      r_rd   = 8'($urandom);
      r_npre = $urandom_range(0, 6);
      pick   = 4'($urandom_range(0, 2));
      r_pre  = (pick == 0) ? 4'h5 : (pick == 1) ? 4'h6 : 4'hF;
      pick   = 4'($urandom_range(0, 5));
      case (pick)
        4'd0, 4'd1, 4'd2: r_fin = 4'h0;
        4'd3, 4'd4:       r_fin = 4'hA;
        default:          r_fin = 4'($urandom_range(1, 4)) | 4'h8; // 9,B,C..: not a defined code
      endcase
      if (r_fin == 4'hA && pick == 5) r_fin = 4'h9;
      build_model(r_wr, r_addr, r_wd, r_rd, r_npre, r_pre, r_fin, m_rd, m_e, m_l);
      run_txn(r_wr, r_addr, r_wd, $sformatf("r%0d", i), o_rd, o_e, o_l, ts, trsp);
      chk($sformatf("r%0d rdata", i), o_rd, m_rd);
      chk($sformatf("r%0d err", i), o_e, m_e);
      chk($sformatf("r%0d latency", i), o_l, m_l);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
# lpc_host

LPC host-side I/O cycle generator: the initiator end of the LPC bus that the codebase's peripheral (UART bridge) answers. It accepts single-byte I/O read/write requests on a valid/ready interface and runs the matching LPC ISA I/O cycle: START, CYCTYPE/DIR, ADDR, DATA, TAR, SYNC, TAR. It returns read data or an error on a one-cycle response strobe. It sits between a host-side register master (or bench driver) and the shared LAD[3:0]/LFRAME# pins.

## Interface
- `NO_DEV_CYCLES`, default 3: consecutive SYNC-phase cycles reading 4'hF before the host aborts (no device).
- `WAIT_LIMIT`, default 1024: maximum cycles spent in short/long wait (SYNC 0101/0110) before the host aborts.
- `lpc_clk` (in, 1): single clock. All logic is on the rising edge.
- `lpc_rst` (in, 1): reset, **asynchronous, active-high**.
- `req_valid` (in, 1): request present.
- `req_ready` (out, 1): host idle and able to accept a request.
- `req_write` (in, 1): 1 = IOWR, 0 = IORD.
- `req_addr` (in, 16): I/O address.
- `req_wdata` (in, 8): write data.
- `rsp_valid` (out, 1): one-cycle completion strobe.
- `rsp_rdata` (out, 8): read data. 8'hFF on writes and on abort.
- `rsp_err` (out, 1): SYNC error, timeout or no-device abort.
- `lpc_frame` (out, 1): LFRAME#, low = start/abort.
- `lpc_ad_out` (out, 4): LAD drive value.
- `lpc_ad_oe` (out, 1): LAD output enable. The tristate sits at the top level.
- `lpc_ad_in` (in, 4): sampled LAD.

## Operation
- Request accepted when `req_valid & req_ready`. Fields are latched and `req_ready` drops in the same edge.
- **Write sequence:**
  - START: frame=0, AD=0000.
  - CTDIR: AD=0010.
  - ADDR: 4 nibbles, [15:12] first.
  - WDATA: 2 nibbles, [3:0] first.
  - TAR_H: AD=1111, driven.
  - TAR_F: AD floated.
  - SYNC.
  - TAR_P1, TAR_P2: floated.
  - DONE.
- **Read sequence:** START, CTDIR (AD=0000), ADDR×4, TAR_H, TAR_F, SYNC, RDATA×2 (low nibble first, sampled), TAR_P1, TAR_P2, DONE.
- `lpc_ad_oe`=1 in START..TAR_H and ABORT. 0 everywhere else, including IDLE.
- **SYNC decode:**
  - 0000: ready; advance.
  - 1010: error; advance, set err flag. A read still captures the data nibbles.
  - 0101 / 0110: wait; stay and increment the wait counter.
  - 1111: stay and increment the no-device counter.
  - Any other value: treated as error and goes to ABORT.
- No-device counter reaches `NO_DEV_CYCLES`, or wait counter reaches `WAIT_LIMIT`: go to ABORT.
- **ABORT:** frame=0, AD=1111, driven for 4 cycles. Then one cycle with frame=1, AD=1111 driven. Then DONE with `rsp_err`=1, `rsp_rdata`=8'hFF.
- **DONE:** `rsp_valid`=1 for one cycle, then IDLE with `req_ready`=1 the following cycle.
- ADDR and data nibble position uses a 2-bit counter. Counters saturate, never wrap.
- `req_valid` during busy is ignored (no accept).

## Timing
- **Reset values (asynchronous):** state=IDLE, `lpc_frame`=1, `lpc_ad_oe`=0, `lpc_ad_out`=4'hF, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=8'hFF, `rsp_err`=0, all counters 0.
- `req_ready` is registered: it rises on the first edge after reset deassertion.
- Zero-wait cycle: START drives on the edge after accept. Reads and writes are both 13 bus cycles. `rsp_valid` follows 1 cycle after TAR_P2, giving 15 edges from accept to `rsp_valid`.
- Each SYNC wait cycle adds exactly 1 cycle of latency.
- Back-to-back: the next START can come no earlier than 2 cycles after `rsp_valid` (ready high 1 cycle after `rsp_valid`).
- Reset asserted mid-cycle: all outputs return to reset values immediately, with no abort frame and no `rsp_valid`.
- SYNC is evaluated on the sampled value at the edge. The RDATA nibble is captured on the same edge the state advances.

## Structure
- `lpc_host_pkg`:
  - state enum: IDLE, START, CTDIR, ADDR, WDATA, TAR_H, TAR_F, SYNC, RDATA, TAR_P1, TAR_P2, ABORT, DONE.
  - constants: CT_IORD=4'b0000, CT_IOWR=4'b0010, START_ISA=4'b0000, SYNC_READY=0000, SYNC_SHORT=0101, SYNC_LONG=0110, SYNC_ERR=1010, LAD_IDLE=1111.
- One module. No sub-module is needed; the LAD tristate stays outside.

## Test plan
- Write 0x03F8 data 0x5A, responder SYNC=0000 → AD seq 0,2,0,3,F,8,A,5,F,Z,0(in),Z,Z; frame low only at START; `rsp_valid` 15 edges after accept, `rsp_err`=0.
- Read 0x03FD, responder SYNC 0000 then nibbles 0,6 → `rsp_rdata`=0x60, `rsp_err`=0.
- Read with SYNC 0110×5 then 0000, data 0xA5 → `rsp_rdata`=0xA5, latency 20.
- No responder (AD=1111) → after 3 SYNC cycles: frame low 4 cycles with AD=1111 driven, `rsp_err`=1, `rsp_rdata`=0xFF.
- SYNC=1010 on read, data 0x33 → `rsp_rdata`=0x33, `rsp_err`=1; two back-to-back writes → second START exactly 2 cycles after first `rsp_valid`.
- `lpc_rst` pulse during ADDR → `lpc_frame`=1, `lpc_ad_oe`=0 immediately, no `rsp_valid`, `req_ready`=1 one edge after release.
